uart_tx: RTL
============

Name: uart_tx

Overview:
- UART transmitter: serialises one byte per request as start bit, 8 data bits (LSB first), optional odd parity and one stop bit on a single line.
- Sits between a byte source (switch/button top level or a message sequencer) and the board's TX pin.
- Uses the same four-phase Send/Sent handshake and baud timing as the receiver side, so a loopback of Sout into the receiver decodes correctly.

Parameters:
- CLK_FREQUENCY, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 19_200, line rate in bits per second. BIT_CLOCKS = CLK_FREQUENCY/BAUD_RATE, integer division (5208 at defaults).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- Send  input  1  request to transmit Din; four-phase handshake, synchronous to clk.
- Din  input  8  byte to transmit; sampled only on handshake acceptance.
- Sent  output  1  frame complete acknowledge.
- Sout  output  1  serial line; idle high; registered.
- Busy  output  1  high from acceptance until return to IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, Sout=1, Sent=0, Busy=0, baud counter=0, bit counter=0, data register=0. Reset mid-frame forces Sout high at once and abandons the frame. No partial-frame resume.
- Baud counter: counts 0..BIT_CLOCKS-1 within each bit, then wraps. It is cleared on every state entry, so every bit lasts exactly BIT_CLOCKS cycles.
- Bit counter: 3 bits, 0..7, indexes the data bit. Transition out of DATA occurs when bit counter=7 and baud counter=BIT_CLOCKS-1.
- IDLE: Sout=1, Busy=0, Sent=0. If Send=1 on a clk edge:
  - latch Din into the shift/data register;
  - go to START;
  - Busy=1 from the next cycle.
- START: Sout=0 for BIT_CLOCKS cycles, then DATA. Sout falls exactly 1 cycle after the edge where Send is sampled high.
- DATA: Sout=data[bit counter], LSB first, BIT_CLOCKS cycles per bit. After bit 7 go to PAR (macro defined) or STOP (undefined).
- PAR: Sout = ~^data (odd parity: total ones over data+parity is odd), BIT_CLOCKS cycles, then STOP.
- STOP: Sout=1 for BIT_CLOCKS cycles, then ACK.
- ACK: Sout=1, Sent=1, Busy=1. Stay while Send=1. When Send=0, go to IDLE; Sent and Busy drop the following cycle.
  - If Send was already low on ACK entry, Sent is high for exactly 1 cycle.
- Din changes after acceptance are ignored. Send deasserted mid-frame does not abort; the frame completes normally.
- Send held high through ACK never retriggers; a new frame requires Send low then high again.
- Frame length, acceptance edge to ACK entry: 11*BIT_CLOCKS cycles with parity, 10*BIT_CLOCKS without.
- Sout is glitch-free: driven from a flop, never combinationally from state.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PAR state present; 11-bit frame (start, 8 data, odd parity, stop); matches the receiver's parity check.
- Undefined: PAR state and parity logic are compiled out; DATA goes straight to STOP; 10-bit frame (8N1). All other timing and handshake rules are unchanged.

Test Plan:
- Reset during idle and mid-DATA (rst pulse 3 cycles) -> Sout=1, Sent=0, Busy=0 immediately, asynchronously. After release, the line stays idle high with no spurious start bit.
- Send=1 with Din=8'h41, held until Sent -> Sout low exactly 1 cycle after acceptance; then bits 1,0,0,0,0,0,1,0, then parity 1, then stop 1. Each bit is 5208 cycles. Sent rises 57288 cycles after acceptance.
- Parity sweep with UART_TX_PARITY_EN defined -> Din=8'h00 gives parity 1; 8'hFF gives 1; 8'h01 gives 0; 8'h03 gives 1.
- Send pulsed 1 cycle with Din=8'hA5; Din changed to 8'h00 and Send dropped on the next cycle -> full frame of 8'hA5 transmitted; Sent high exactly 1 cycle; Busy falls 1 cycle later.
- Send held high for 3 frames' worth of time -> exactly one frame sent, Sent stays high. After Send falls, Sent and Busy fall the next cycle; a second Send rise sends a second frame.
- Build without UART_TX_PARITY_EN; loopback Sout into the receiver with parity disabled; send 8'h5A then 8'hC3 -> each frame is 52080 cycles; the receiver decodes 8'h5A and 8'hC3 with no framing error.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional odd parity, one stop bit.
// Optional parity bit enabled by defining UART_TX_PARITY_EN; default build is 8N1.
module uart_tx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Send,
  input  logic [7:0] Din,
  output logic       Sent,
  output logic       Sout,
  output logic       Busy
);

  localparam int BIT_CLOCKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW = (BIT_CLOCKS > 1) ? $clog2(BIT_CLOCKS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CLOCKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_ACK
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_baud, w_baud_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [7:0]      r_data, w_data_next;
  logic            w_sout_next;
  logic            w_bit_end;

  assign w_bit_end = (r_baud == BAUD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit;
    w_data_next  = r_data;
    w_baud_next  = r_baud + CW'(1);
    w_sout_next  = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (Send) begin
          w_data_next  = Din;
          w_bit_next   = 3'd0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = S_PAR;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next  = r_bit + 3'd1;
            w_baud_next = '0;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PAR: begin
        if (w_bit_end) w_state_next = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bit_end) w_state_next = S_ACK;
      end
      S_ACK: begin
        if (!Send) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // Every state entry restarts the bit timer so each bit is exactly BIT_CLOCKS long.
    if (w_state_next != r_state || r_state == S_IDLE || r_state == S_ACK)
      w_baud_next = '0;

    // Line level is computed from the next state so Sout comes straight off a flop.
    case (w_state_next)
      S_START: w_sout_next = 1'b0;
      S_DATA:  w_sout_next = w_data_next[w_bit_next];
`ifdef UART_TX_PARITY_EN
      S_PAR:   w_sout_next = ~^w_data_next;
`endif
      default: w_sout_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= 3'd0;
      r_data  <= 8'd0;
      Sout    <= 1'b1;
      Sent    <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_data  <= w_data_next;
      Sout    <= w_sout_next;
      Sent    <= (w_state_next == S_ACK);
      Busy    <= (w_state_next != S_IDLE);
    end
  end

endmodule
